// File: rtl/ld_field.sv
// ld_field: MIX load-with-field unit. Fetches one memory word, extracts
// field (L:R), right-justifies the bytes into a register word and applies
// the optional LDxN sign inversion. Signals completion with a one-cycle stop.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; rejects invalid fields without a read
// READ    | mem_rd held high with a stable mem_addr until mem_ack
// EXTRACT | memory word captured; result registered, stop pulsed
module ld_field #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [5:0]    field,
  input  logic          negate,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [30:0]   mem_data,
  output logic [30:0]   out,
  output logic          stop,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, READ, EXTRACT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  l_q, r_q;
  logic        neg_q;
  logic [30:0] data_q;
  logic        err_pend_q;

  logic        field_ok;
  logic        accept, reject, capture, finish;
  logic [30:0] result;

  assign field_ok = (field[5:3] <= field[2:0]) && (field[2:0] <= 3'd5);

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (field_ok) begin
            accept  = 1'b1;
            state_d = READ;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          capture = 1'b1;
          state_d = EXTRACT;
        end
      end
      EXTRACT: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Field extraction: shift byte R down to [5:0], then keep only the
  // bytes max(L,1)..R. L=0 contributes the sign but no magnitude byte.
  always_comb begin
    int          lo;
    int          r_i;
    int          n;
    int          sh;
    logic [29:0] mask;
    logic [29:0] mag;
    logic        sign;
    r_i    = int'(r_q);
    lo     = (l_q == 3'd0) ? 1 : int'(l_q);
    n      = (r_i >= lo) ? (r_i - lo + 1) : 0;
    sh     = 6 * (5 - r_i);
    mask   = ~({30{1'b1}} << (6 * n));
    mag    = (data_q[29:0] >> sh) & mask;
    sign   = ((l_q == 3'd0) ? data_q[30] : 1'b0) ^ neg_q;
    result = {sign, mag};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, memory handshake and result/pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q        <= '0;
      r_q        <= '0;
      neg_q      <= 1'b0;
      data_q     <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      err_pend_q <= 1'b0;
      out        <= '0;
      stop       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err_pend_q <= reject;
      stop       <= finish | err_pend_q;
      err        <= err_pend_q;
      if (accept) begin
        l_q      <= field[5:3];
        r_q      <= field[2:0];
        neg_q    <= negate;
        mem_addr <= addr;
        mem_rd   <= 1'b1;
      end
      if (capture) begin
        data_q <= mem_data;
        mem_rd <= 1'b0;
      end
      if (finish)          out <= result;
      else if (err_pend_q) out <= '0;
    end
  end

endmodule

// File: tb/tb_ld_field.sv
// tb_ld_field: scoreboard bench for ld_field. Each request pushes its
// expected {err,out} when issued; the monitor pops on every stop pulse.
module tb_ld_field;
  localparam int AW = 12;
  localparam logic [30:0] W = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [5:0]    field = '0;
  logic          negate = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack = 1'b0;
  logic [30:0]   mem_data = '0;
  logic [30:0]   out;
  logic          stop;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int stop_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic stop_prev = 1'b0;
  logic rd_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;

  ld_field #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .field(field),
    .negate(negate), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
    .mem_data(mem_data), .out(out), .stop(stop), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] model(input logic [2:0] l, input logic [2:0] r,
                                        input logic neg, input logic [30:0] w);
    logic [29:0] mag;
    logic s;
    int lo;
    mag = '0;
    s  = ((l == 3'd0) ? w[30] : 1'b0) ^ neg;
    lo = (l == 3'd0) ? 1 : int'(l);
    for (int i = lo; i <= int'(r); i++) mag = {mag[23:0], w[35-6*i -: 6]};
    return {s, mag};
  endfunction

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    if (stop) begin
      stop_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_stop: got err=%b out=%h, required no stop", err, out);
      end else begin
        e = exp_q.pop_front();
        if ({err, out} !== e) begin
          n_bad++;
          $display("FAIL result: got err=%b out=%h, required err=%b out=%h", err, out, e[31], e[30:0]);
        end
      end
      n_cmp++;
      if (stop_prev) begin
        n_bad++;
        $display("FAIL stop_width: got stop high 2 cycles, required 1");
      end
    end
    if (mem_rd && rd_prev) begin
      n_cmp++;
      if (mem_addr !== addr_prev) begin
        n_bad++;
        $display("FAIL addr_stable: got %h, required %h", mem_addr, addr_prev);
      end
    end
    stop_prev = stop;
    rd_prev   = mem_rd;
    addr_prev = mem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one start cycle (called at a negedge, returns one negedge later).
  task automatic issue(input logic [2:0] l, input logic [2:0] r, input logic neg,
                       input logic [AW-1:0] a);
    start = 1'b1; field = {l, r}; negate = neg; addr = a;
    if (l <= r && r <= 3'd5) exp_q.push_back({1'b0, model(l, r, neg, mem_data)});
    else                     exp_q.push_back({1'b1, 31'd0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ack_after(input int d);
    repeat (d - 1) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic wait_stop(input int budget);
    int k = 0;
    while (!stop && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!stop) begin
      n_bad++;
      $display("FAIL stop_timeout: got no stop in %0d cycles, required stop", budget);
    end
  endtask

  task automatic run_valid(input logic [2:0] l, input logic [2:0] r, input logic neg,
                           input logic [AW-1:0] a, input int d);
    issue(l, r, neg, a);
    ack_after(d);
    wait_stop(20);
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 5;
    if (out !== 31'd0) begin n_bad++; $display("FAIL reset_out: got %h, required 0", out); end
    if (stop !== 1'b0) begin n_bad++; $display("FAIL reset_stop: got %b, required 0", stop); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b, required 0", err); end
    if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd: got %b, required 0", mem_rd); end
    if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    mem_data = W;
    issue(3'd0, 3'd5, 1'b0, 12'h0a5);
    n_cmp += 2;
    if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL full_mem_rd: got %b, required 1", mem_rd); end
    if (mem_addr !== 12'h0a5) begin n_bad++; $display("FAIL full_mem_addr: got %h, required 0a5", mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if (stop !== 1'b0) begin n_bad++; $display("FAIL full_early_stop: got %b, required 0", stop); end
    @(negedge clk);
    n_cmp++;
    if (stop !== 1'b1) begin n_bad++; $display("FAIL full_latency: got stop=%b, required 1", stop); end
  endtask

  task automatic test_back_to_back();
    mem_data = W;
    run_valid(3'd1, 3'd5, 1'b0, 12'h010, 1);
    run_valid(3'd3, 3'd3, 1'b0, 12'h011, 1);
    run_valid(3'd4, 3'd5, 1'b1, 12'h012, 1);
    @(negedge clk);
  endtask

  task automatic test_invalid(input logic [2:0] l, input logic [2:0] r);
    issue(l, r, 1'b0, 12'h3ff);
    n_cmp += 2;
    if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL invalid_mem_rd: got %b, required 0", mem_rd); end
    if (stop !== 1'b0) begin n_bad++; $display("FAIL invalid_early_stop: got %b, required 0", stop); end
    @(negedge clk);
    n_cmp += 3;
    if (stop !== 1'b1) begin n_bad++; $display("FAIL invalid_stop: got %b, required 1", stop); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL invalid_err: got %b, required 1", err); end
    if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL invalid_mem_rd2: got %b, required 0", mem_rd); end
    @(negedge clk);
  endtask

  task automatic test_sign_only();
    mem_data = W;
    run_valid(3'd0, 3'd0, 1'b0, 12'h020, 2);
    run_valid(3'd0, 3'd0, 1'b1, 12'h021, 1);
    @(negedge clk);
  endtask

  task automatic test_delayed_ack();
    int cnt0;
    cnt0 = stop_cnt;
    mem_data = 31'h2a5c3e91;
    issue(3'd2, 3'd4, 1'b0, 12'h123);
    for (int k = 0; k < 4; k++) begin
      n_cmp += 2;
      if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL delay_mem_rd: got %b, required 1", mem_rd); end
      if (mem_addr !== 12'h123) begin n_bad++; $display("FAIL delay_mem_addr: got %h, required 123", mem_addr); end
      start = 1'b1; field = 6'o15; addr = 12'h777;
      @(negedge clk);
      start = 1'b0;
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    wait_stop(20);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (stop_cnt !== cnt0 + 1) begin
      n_bad++;
      $display("FAIL delay_stop_count: got %0d, required %0d", stop_cnt - cnt0, 1);
    end
  endtask

  task automatic test_reset_mid();
    int cnt0;
    mem_data = W;
    run_valid(3'd0, 3'd5, 1'b0, 12'h040, 1);
    @(negedge clk);
    issue(3'd1, 3'd5, 1'b0, 12'h041);
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    n_cmp += 3;
    if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_rd: got %b, required 0", mem_rd); end
    if (out !== 31'd0) begin n_bad++; $display("FAIL rstmid_out: got %h, required 0", out); end
    if (stop !== 1'b0) begin n_bad++; $display("FAIL rstmid_stop: got %b, required 0", stop); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = stop_cnt;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp += 2;
    if (stop_cnt !== cnt0) begin n_bad++; $display("FAIL rstmid_late_ack: got %0d stops, required 0", stop_cnt - cnt0); end
    if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_rd: got %b, required 0", mem_rd); end
    mem_data = 31'h15a5a5a5;
    run_valid(3'd2, 3'd5, 1'b1, 12'h042, 3);
    @(negedge clk);
  endtask

  task automatic test_sweep();
    for (int l = 0; l <= 5; l++) begin
      for (int r = l; r <= 5; r++) begin
        mem_data = 31'($urandom);
        run_valid(3'(l), 3'(r), 1'($urandom_range(0, 1)), 12'($urandom), int'($urandom_range(1, 3)));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_invalid(3'd3, 3'd2);
    test_invalid(3'd0, 3'd6);
    test_sign_only();
    test_delayed_ack();
    test_reset_mid();
    test_sweep();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ld_field.md
# ld_field

Load-with-field unit for the MIX datapath. It is the read-side counterpart of the store-with-field merger. On `start` it fetches one memory word and extracts field (L:R). The extracted bytes are right-justified into a register-format word, with optional sign negation (LDA/LDX/LDi vs LDAN/LDXN/LDiN). It sits between the instruction sequencer and the memory port, and returns a one-cycle `stop` pulse when the result is valid.

## Interface
Parameters:
- `AW`, 12, memory address width (4000-word MIX store).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `addr`  in  AW  effective address, captured on `start`.
- `field`  in  6  field spec F = 8L+R; `field[5:3]`=L, `field[2:0]`=R; captured on `start`.
- `negate`  in  1  invert result sign (LDxN); captured on `start`.
- `mem_addr`  out  AW  registered read address.
- `mem_rd`  out  1  read request; held high until acknowledged.
- `mem_ack`  in  1  memory has `mem_data` valid this cycle.
- `mem_data`  in  31  memory word: bit 30 sign, byte1=[29:24] … byte5=[5:0].
- `out`  out  31  extracted register word; holds last result.
- `stop`  out  1  one-cycle completion pulse.
- `err`  out  1  high with `stop` when field is invalid.

## Operation
- States: IDLE, READ, EXTRACT.
- IDLE:
  - `start`=1 with a valid field (L≤R, R≤5): latch `addr`, `field` and `negate`; drive `mem_addr`←`addr` and `mem_rd`←1; go to READ.
  - `start`=1 with an invalid field: no memory access. Next edge: `out`←0, `err`←1, `stop`←1; stay IDLE.
- READ: wait for `mem_ack`. On an edge with `mem_ack`=1: latch `mem_data`, `mem_rd`←0, go to EXTRACT. `mem_ack` seen in IDLE or EXTRACT is ignored.
- EXTRACT: compute and register the result; `stop`←1; go to IDLE.
- Extraction rules:
  - Sign: if L=0, sign=`mem_data[30]`; otherwise sign=+ (0). If `negate`=1, sign is inverted, including for a zero magnitude.
  - Magnitude: bytes max(L,1)..R, byte R placed at [5:0], byte R-1 at [11:6], and so on. All higher bits are zero.
  - (0:0) gives sign only with zero magnitude. (0:5) and (1:5) copy all five bytes.
- `start` while in READ or EXTRACT is ignored; there is no queueing.
- `out` changes only on completion (valid or error). It is never cleared by a new `start`.

## Timing
- Reset values: `out`=0, `stop`=0, `err`=0, `mem_rd`=0, `mem_addr`=0, state IDLE.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). An in-flight read is abandoned and a late `mem_ack` is ignored.
- Latency, valid field:
  - `start` is sampled at edge T0; `mem_rd`=1 from T0.
  - `mem_ack` is sampled at edge Ta, where Ta ≥ T0+1.
  - `out` is valid and `stop`=1 for the cycle after edge Ta+1.
  - With a zero-wait memory (ack in the first READ cycle), `stop` is high 2 cycles after `start`.
- Latency, invalid field: `stop`=`err`=1 for the one cycle after edge T0+1.
- `stop` and `err` are single-cycle pulses. `err`=0 on every valid completion.
- `mem_addr` is stable for the whole time `mem_rd`=1.
- Back-to-back operation: `start` may be asserted in the same cycle `stop` is high; that request is accepted.

## Test plan
Test word W: sign −, bytes 01,02,03,04,05, i.e. W = {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5}.
- (0:5), negate=0, ack after 1 cycle -> `out`=W; `stop` 2 cycles after `start`; `err`=0.
- (1:5), then (3:3), then (4:5) with negate=1, issued back-to-back -> +{1,2,3,4,5}, then +{0,0,0,0,3}, then −{0,0,0,4,5}.
- (0:0), then (0:0) with negate=1 -> `out`=−0, then +0, i.e. 31'h40000000 then 31'h0.
- Invalid field F=8·3+2 -> `mem_rd` never asserted; `stop`=`err`=1 one cycle after `start`, `out`=0. Also check R=6 is rejected.
- `mem_ack` delayed 5 cycles, with extra `start` pulses during READ -> `mem_rd` held with stable `mem_addr`; extra starts ignored; exactly one `stop`.
- `rst_n` pulsed low during READ, then a late `mem_ack` -> `mem_rd`=0 and `out`=0 immediately; no `stop`; the next `start` completes normally.
